// File: rtl/apu_event_trigger.sv
// Event-to-APU trigger arbiter: edge-detects game events, queues them, and issues at most one
// one-hot sound trigger per clock with highest-index priority and per-channel frame holdoff.
module apu_event_trigger #(
    parameter int NUM_CH         = 3,
    parameter int HOLDOFF_FRAMES = 4,
    parameter int HOLDOFF_W      = 4,
    parameter int CH_IDX_W       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_end,
    input  logic                test_mode,
    input  logic [NUM_CH-1:0]   event_in,
    input  logic [NUM_CH-1:0]   ch_enable,
    output logic [NUM_CH-1:0]   trigger_out,
    output logic                trig_valid,
    output logic [CH_IDX_W-1:0] ch_idx,
    output logic [7:0]          drop_count
);

    logic [NUM_CH-1:0]    event_buf;
    logic [NUM_CH-1:0]    pending;
    logic [HOLDOFF_W-1:0] holdoff [NUM_CH];

    logic [NUM_CH-1:0]    edge_det;
    logic [NUM_CH-1:0]    ok;
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    grant;
    logic [NUM_CH-1:0]    drop;
    logic [CH_IDX_W-1:0]  grant_idx;

    // Ascending scan so the highest requesting index overwrites lower ones.
    always_comb begin
        edge_det  = event_in & ~event_buf;
        ok        = '0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ok[i] = ch_enable[i] && (holdoff[i] == '0);
        end
        req  = (pending | edge_det) & ok;
        drop = edge_det & ~ok;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = CH_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_buf   <= '0;
            pending     <= '0;
            trigger_out <= '0;
            trig_valid  <= 1'b0;
            ch_idx      <= '0;
            drop_count  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                holdoff[i] <= '0;
            end
        end else begin
            event_buf <= event_in;
            if (test_mode) begin
                trigger_out <= event_in & ch_enable;
                trig_valid  <= 1'b0;
                ch_idx      <= '0;
                pending     <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    holdoff[i] <= '0;
                end
            end else begin
                trigger_out <= grant;
                trig_valid  <= |grant;
                ch_idx      <= grant_idx;
                pending     <= req & ~grant;
                if ((|drop) && (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
                // A fresh grant reloads the holdoff even on a frame_end cycle.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (grant[i]) begin
                        holdoff[i] <= HOLDOFF_W'(HOLDOFF_FRAMES);
                    end else if (frame_end && (holdoff[i] != '0)) begin
                        holdoff[i] <= holdoff[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apu_event_trigger.sv
// Directed bench for apu_event_trigger (3 channels, 2-frame holdoff) with hand-computed expectations.
module tb_apu_event_trigger;

    logic       clk;
    logic       reset;
    logic       frame_end;
    logic       test_mode;
    logic [2:0] event_in;
    logic [2:0] ch_enable;
    logic [2:0] trigger_out;
    logic       trig_valid;
    logic [1:0] ch_idx;
    logic [7:0] drop_count;

    int err_count   = 0;
    int check_count = 0;

    apu_event_trigger #(
        .NUM_CH(3), .HOLDOFF_FRAMES(2), .HOLDOFF_W(4), .CH_IDX_W(2)
    ) dut (
        .clk(clk), .reset(reset), .frame_end(frame_end), .test_mode(test_mode),
        .event_in(event_in), .ch_enable(ch_enable), .trigger_out(trigger_out),
        .trig_valid(trig_valid), .ch_idx(ch_idx), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, let one rising edge sample them, then settle 1ns past the edge.
    task automatic applyStimulus(input logic [2:0] ev, input logic [2:0] en,
                                 input logic fe, input logic tm);
        event_in  = ev;
        ch_enable = en;
        frame_end = fe;
        test_mode = tm;
        @(posedge clk);
        #1;
    endtask

    task automatic checkTrig(input string tag, input logic [2:0] trig,
                             input logic valid, input logic [1:0] idx);
        checkOutput({tag, ".trig"},  32'(trigger_out), 32'(trig));
        checkOutput({tag, ".valid"}, 32'(trig_valid),  32'(valid));
        checkOutput({tag, ".idx"},   32'(ch_idx),      32'(idx));
    endtask

    // Two frame_end pulses with idle events clear every 2-frame holdoff.
    task automatic clearHoldoff();
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        event_in = '0; ch_enable = 3'b111; frame_end = 1'b0; test_mode = 1'b0;
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        checkTrig("reset_hold", 3'b000, 1'b0, 2'd0);
        checkOutput("reset_hold.drop", 32'(drop_count), 32'd0);
        reset = 1'b0;
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);

        // Async reset mid-cycle while ch2 trigger is showing
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0);
        checkTrig("pre_reset", 3'b100, 1'b1, 2'd2);
        #2;
        reset    = 1'b1;
        event_in = 3'b000;
        #1;
        checkTrig("async_reset", 3'b000, 1'b0, 2'd0);
        checkOutput("async_reset.drop", 32'(drop_count), 32'd0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);

        // Single edge on ch0 then held level: exactly one trigger
        applyStimulus(3'b001, 3'b111, 1'b0, 1'b0);
        checkTrig("single_fire", 3'b001, 1'b1, 2'd0);
        applyStimulus(3'b001, 3'b111, 1'b0, 1'b0);
        checkTrig("held_1", 3'b000, 1'b0, 2'd0);
        applyStimulus(3'b001, 3'b111, 1'b0, 1'b0);
        checkTrig("held_2", 3'b000, 1'b0, 2'd0);
        clearHoldoff();

        // Simultaneous edges on all channels serialise highest first
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0);
        checkTrig("simul_0", 3'b100, 1'b1, 2'd2);
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0);
        checkTrig("simul_1", 3'b010, 1'b1, 2'd1);
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0);
        checkTrig("simul_2", 3'b001, 1'b1, 2'd0);
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0);
        checkTrig("simul_3", 3'b000, 1'b0, 2'd0);
        checkOutput("simul.drop", 32'(drop_count), 32'd0);
        clearHoldoff();

        // Holdoff: retrigger after one frame is dropped, after two it fires
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0);
        checkTrig("hold_fire", 3'b100, 1'b1, 2'd2);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0);
        checkTrig("hold_blocked", 3'b000, 1'b0, 2'd0);
        checkOutput("hold_blocked.drop", 32'(drop_count), 32'd1);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0);
        checkTrig("hold_expired", 3'b100, 1'b1, 2'd2);
        checkOutput("hold_expired.drop", 32'(drop_count), 32'd1);
        clearHoldoff();

        // Test mode: masked level passthrough, no valid, drop_count frozen
        applyStimulus(3'b101, 3'b111, 1'b0, 1'b1);
        checkTrig("test_0", 3'b101, 1'b0, 2'd0);
        applyStimulus(3'b101, 3'b111, 1'b0, 1'b1);
        checkTrig("test_1", 3'b101, 1'b0, 2'd0);
        applyStimulus(3'b111, 3'b011, 1'b0, 1'b1);
        checkTrig("test_mask", 3'b011, 1'b0, 2'd0);
        checkOutput("test.drop", 32'(drop_count), 32'd1);
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0);
        checkTrig("test_exit", 3'b000, 1'b0, 2'd0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);

        // Pending ch1 cancelled by disable; no refire without new edge
        applyStimulus(3'b110, 3'b111, 1'b0, 1'b0);
        checkTrig("pend_ch2", 3'b100, 1'b1, 2'd2);
        applyStimulus(3'b110, 3'b101, 1'b0, 1'b0);
        checkTrig("pend_disabled", 3'b000, 1'b0, 2'd0);
        applyStimulus(3'b110, 3'b111, 1'b0, 1'b0);
        checkTrig("pend_reenabled", 3'b000, 1'b0, 2'd0);
        applyStimulus(3'b110, 3'b111, 1'b0, 1'b0);
        checkTrig("pend_idle", 3'b000, 1'b0, 2'd0);
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0);
        applyStimulus(3'b110, 3'b111, 1'b0, 1'b0);
        checkTrig("pend_new_edge", 3'b010, 1'b1, 2'd1);
        checkOutput("pend.drop", 32'(drop_count), 32'd1);

        // drop_count saturation with all channels disabled
        for (int i = 0; i < 300; i++) begin
            applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
            applyStimulus(3'b001, 3'b000, 1'b0, 1'b0);
        end
        checkOutput("drop_sat", 32'(drop_count), 32'd255);
        checkTrig("drop_sat", 3'b000, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
